i2s_rx: RTL and testbench
=========================

// Module: i2s_rx
// PURPOSE
//  I2S receiver for the codec ADC path. Samples codec serial data (DOUT) against the
//  SCLK/LRCLK pair that the I2S transmitter drives (SCLK = MCLK/4, LRCLK = MCLK/256).
//  Deserialises 24-bit left/right words, MSB first. Presents each stereo pair to the
//  audio core via a valid/ack handshake, with overrun and framing-error flags.
//  All logic runs on MCLK; SCLK and LRCLK are data inputs and are never used as clocks.
// PARAMETERS
//  DATA_WIDTH   24  bits captured per channel, MSB first
//  SYNC_STAGES  2   flop stages synchronising SCLK, LRCLK and DOUT into MCLK (>=2)
//  CNT_WIDTH    6   rise-counter width; saturates at 2**CNT_WIDTH-1
// PORTS
//  MCLK          in   1           master clock, 256*44.1 kHz
//  RESET         in   1           synchronous, active-high
//  SCLK          in   1           bit clock, MCLK/4
//  LRCLK         in   1           word select: 0 = left slot, 1 = right slot
//  DOUT          in   1           serial data from codec ADC
//  SAMPLE_ACK    in   1           consumer accepts the pair held on LEFT/RIGHT
//  LEFT          out  DATA_WIDTH  last complete left word
//  RIGHT         out  DATA_WIDTH  last complete right word
//  SAMPLE_VALID  out  1           pair on LEFT/RIGHT is new and not yet accepted
//  OVERRUN       out  1           sticky: a pair was dropped while SAMPLE_VALID was high
//  FRAME_ERR     out  1           one-MCLK pulse: a slot ended short and was discarded
// BEHAVIOUR
//  - Reset: all outputs 0. Sync flops, shift register and counter cleared. FSM -> WAIT.
//  - SCLK, LRCLK and DOUT share one SYNC_STAGES synchroniser, so their relative order is
//    preserved. A rise is sync'd SCLK 0->1 and an LR edge is any change of sync'd LRCLK,
//    both seen against the previous sync'd sample.
//  - Rise counter r: cleared to 0 on an LR edge, +1 on each rise, saturates at max.
//    If an LR edge and a rise occur in the same cycle, r becomes 1.
//  - Standard I2S one-bit delay: rise r=1 after an LR edge carries the previous word's
//    last bit and is ignored. Rises r=2..DATA_WIDTH+1 shift sync'd DOUT in MSB first.
//    Rises beyond DATA_WIDTH+1 are ignored; the slot may be longer (32-bit slots).
//  - FSM states:
//    WAIT  : idle after reset or error. LRCLK 1->0 edge -> LEFT. Other edges ignored,
//            so a partial frame at start-up is discarded.
//    LEFT  : LR edge 0->1 with r>=DATA_WIDTH+1 -> latch shift reg as left word, -> RIGHT.
//            LR edge with r<DATA_WIDTH+1 -> FRAME_ERR pulse, -> WAIT.
//    RIGHT : on rise r=DATA_WIDTH+1 the right word is complete:
//            - If SAMPLE_VALID=0 or SAMPLE_ACK=1 this cycle: next cycle LEFT<=latched
//              left, RIGHT<=word, SAMPLE_VALID<=1.
//            - Otherwise keep outputs, drop the pair, OVERRUN<=1.
//            LR edge 1->0: r>=DATA_WIDTH+1 -> LEFT. Short slot -> FRAME_ERR, -> WAIT.
//  - Latency: outputs update exactly 1 MCLK after the rise-detect cycle of the right LSB.
//  - Handshake: SAMPLE_VALID stays high until a cycle with SAMPLE_ACK=1, then clears next
//    cycle. That clear is overridden if a new pair completes in the same cycle.
//    LEFT/RIGHT are stable while SAMPLE_VALID=1. SAMPLE_ACK while VALID=0 is ignored.
//  - OVERRUN: cleared only by RESET. FRAME_ERR never alters LEFT/RIGHT/SAMPLE_VALID.
//  - RESET mid-frame: the partial word is lost. Capture resumes at the next LRCLK 1->0 edge.
//  - Arithmetic: words are raw two's-complement bit patterns, no sign extension or scaling.
// TESTING
//  1 Codec model sends L=24'hABCDEF, R=24'h123456 in 32-bit slots, SAMPLE_ACK tied high
//    -> LEFT=ABCDEF, RIGHT=123456, SAMPLE_VALID 1 MCLK wide, 1 MCLK after right-LSB rise.
//  2 SAMPLE_ACK low, three frames L/R = 000001/800000, 7FFFFF/FFFFFF, 0A0A0A/050505
//    -> outputs hold 000001/800000, OVERRUN=1 after frame 2; ACK then gives a new pair.
//  3 Bench starts mid right slot, then sends a full frame L=111111 R=222222
//    -> no SAMPLE_VALID for the partial frame, then exactly one pair 111111/222222.
//  4 Left slot cut to 20 SCLK rises -> FRAME_ERR one MCLK pulse, no SAMPLE_VALID.
//    The next full frame L=C0FFEE R=BADBAD is captured correctly.
//  5 RESET for 3 MCLK during bit 12 of the left word -> all outputs 0.
//    First SAMPLE_VALID comes from the following full frame, with exact data.
//  6 ACK asserted in the same cycle a new pair completes -> SAMPLE_VALID stays 1,
//    outputs update to the new pair, OVERRUN stays 0.

Source files
------------

// File: rtl/i2s_rx_if.sv
// i2s_rx_if: sample-side bus between the I2S receiver and the audio core.
//   LEFT / RIGHT  : last complete stereo pair (receiver -> core)
//   SAMPLE_VALID  : pair is new and not yet accepted (receiver -> core)
//   SAMPLE_ACK    : core accepts the pair held on LEFT/RIGHT (core -> receiver)
//   OVERRUN       : sticky, a pair was dropped while SAMPLE_VALID was high
//   FRAME_ERR     : one-MCLK pulse, a slot ended short and was discarded
// modport master is used by the receiver, modport slave by the consumer.
interface i2s_rx_if #(
    parameter int DATA_WIDTH = 24
);
    logic [DATA_WIDTH-1:0] LEFT;
    logic [DATA_WIDTH-1:0] RIGHT;
    logic                  SAMPLE_VALID;
    logic                  SAMPLE_ACK;
    logic                  OVERRUN;
    logic                  FRAME_ERR;

    modport master (
        output LEFT, RIGHT, SAMPLE_VALID, OVERRUN, FRAME_ERR,
        input  SAMPLE_ACK
    );

    modport slave (
        input  LEFT, RIGHT, SAMPLE_VALID, OVERRUN, FRAME_ERR,
        output SAMPLE_ACK
    );
endinterface

// File: rtl/i2s_rx.sv
// i2s_rx: I2S receiver for the codec ADC path.
// Oversamples SCLK/LRCLK/DOUT on MCLK (no derived clocks), deserialises 24-bit
// left/right words MSB first with the standard one-bit I2S delay, and presents
// each stereo pair on a valid/ack bus with overrun and framing-error flags.
// Ports:
//   MCLK   in  master clock
//   RESET  in  synchronous, active-high
//   SCLK   in  bit clock (MCLK/4), sampled as data
//   LRCLK  in  word select, 0 = left slot, 1 = right slot
//   DOUT   in  serial data from the codec ADC
//   smp    i2s_rx_if.master: LEFT, RIGHT, SAMPLE_VALID, SAMPLE_ACK, OVERRUN, FRAME_ERR
module i2s_rx #(
    parameter int          DATA_WIDTH  = 24,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int          CNT_WIDTH   = 6
) (
    input  logic     MCLK,
    input  logic     RESET,
    input  logic     SCLK,
    input  logic     LRCLK,
    input  logic     DOUT,
    i2s_rx_if.master smp
);
    localparam logic [CNT_WIDTH-1:0] FULL  = CNT_WIDTH'(DATA_WIDTH + 1);
    localparam logic [CNT_WIDTH-1:0] FIRST = CNT_WIDTH'(2);
    localparam logic [CNT_WIDTH-1:0] ONE   = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_LEFT,
        ST_RIGHT
    } state_t;

    // One shared synchroniser keeps the three lines in their relative order.
    logic [2:0] sync_q [SYNC_STAGES];
    logic       sclk_s, lr_s, dout_s;
    logic       sclk_d, lr_d;
    logic       rise, lr_edge;

    logic [CNT_WIDTH-1:0]  r_q, r_next;
    logic [DATA_WIDTH-1:0] shift_q, left_lat_q, word_now;
    logic [DATA_WIDTH-1:0] left_q, right_q;
    logic                  valid_q, overrun_q, ferr_q;

    state_t state_q, state_d;
    logic   ferr_set, latch_left, complete;

    always_ff @(posedge MCLK) begin
        if (RESET) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            sclk_d <= 1'b0;
            lr_d   <= 1'b0;
        end else begin
            sync_q[0] <= {SCLK, LRCLK, DOUT};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            sclk_d <= sclk_s;
            lr_d   <= lr_s;
        end
    end

    assign sclk_s  = sync_q[SYNC_STAGES-1][2];
    assign lr_s    = sync_q[SYNC_STAGES-1][1];
    assign dout_s  = sync_q[SYNC_STAGES-1][0];
    assign rise    = sclk_s & ~sclk_d;
    assign lr_edge = lr_s ^ lr_d;

    // A rise coinciding with an LR edge is the first rise of the new slot.
    always_comb begin
        r_next = r_q;
        if (lr_edge) begin
            r_next = rise ? ONE : '0;
        end else if (rise && (r_q != '1)) begin
            r_next = r_q + ONE;
        end
    end

    assign word_now = {shift_q[DATA_WIDTH-2:0], dout_s};

    always_ff @(posedge MCLK) begin
        if (RESET) begin
            r_q     <= '0;
            shift_q <= '0;
        end else begin
            r_q <= r_next;
            // Rise 1 carries the previous word's LSB; rises past the word are padding.
            if (rise && !lr_edge && (r_next >= FIRST) && (r_next <= FULL)) begin
                shift_q <= word_now;
            end
        end
    end

    always_ff @(posedge MCLK) begin
        if (RESET) state_q <= ST_WAIT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        ferr_set   = 1'b0;
        latch_left = 1'b0;
        complete   = 1'b0;
        case (state_q)
            ST_WAIT: begin
                // Only a right->left transition starts a frame; a partial frame is skipped.
                if (lr_edge && !lr_s) state_d = ST_LEFT;
            end
            ST_LEFT: begin
                if (lr_edge) begin
                    if (r_q >= FULL) begin
                        latch_left = 1'b1;
                        state_d    = ST_RIGHT;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = ST_WAIT;
                    end
                end
            end
            ST_RIGHT: begin
                if (lr_edge) begin
                    if (r_q >= FULL) begin
                        state_d = ST_LEFT;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = ST_WAIT;
                    end
                end else if (rise && (r_next == FULL)) begin
                    complete = 1'b1;
                end
            end
            default: state_d = ST_WAIT;
        endcase
    end

    always_ff @(posedge MCLK) begin
        if (RESET) begin
            left_lat_q <= '0;
            left_q     <= '0;
            right_q    <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            ferr_q <= ferr_set;
            if (latch_left) left_lat_q <= shift_q;
            // A completing pair takes priority over the ack-driven clear of VALID.
            if (complete) begin
                if (!valid_q || smp.SAMPLE_ACK) begin
                    left_q  <= left_lat_q;
                    right_q <= word_now;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (smp.SAMPLE_ACK) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign smp.LEFT         = left_q;
    assign smp.RIGHT        = right_q;
    assign smp.SAMPLE_VALID = valid_q;
    assign smp.OVERRUN      = overrun_q;
    assign smp.FRAME_ERR    = ferr_q;
endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: directed bench for i2s_rx. A codec model drives 32-bit I2S slots;
// a slot-level model predicts pairs, overruns and framing errors and is compared
// against the DUT outputs on every MCLK cycle.
module tb_i2s_rx;
    localparam int DW  = 24;
    localparam int LAT = 3;   // drive edge -> 2 sync stages -> output register

    logic MCLK  = 1'b0;
    logic RESET = 1'b1;
    logic SCLK  = 1'b0;
    logic LRCLK = 1'b1;
    logic DOUT  = 1'b0;
    logic ack   = 1'b1;

    i2s_rx_if #(.DATA_WIDTH(DW)) bus ();
    assign bus.SAMPLE_ACK = ack;

    i2s_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(2), .CNT_WIDTH(6)) dut (
        .MCLK (MCLK),
        .RESET(RESET),
        .SCLK (SCLK),
        .LRCLK(LRCLK),
        .DOUT (DOUT),
        .smp  (bus)
    );

    always #5 MCLK = ~MCLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int vcount   = 0;
    int fcount   = 0;

    typedef struct {
        int          t;
        bit          is_pair;
        logic [23:0] l;
        logic [23:0] r;
    } ev_t;
    ev_t evq[$];

    logic [23:0] m_left  = '0;
    logic [23:0] m_right = '0;
    bit          m_valid = 0, m_overrun = 0, m_ferr = 0;

    // codec-side slot tracking: 0 = not framed, 1 = in left, 2 = in right
    int          phase = 0;
    int          rises = 0;
    bit          cur_lr = 1;
    bit          last_lsb = 0;
    bit          ack_clear_pending = 0;
    logic [23:0] cur_word = '0;
    logic [23:0] left_saved = '0;

    task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: applies handshake rules to the scheduled slot events.
    initial begin
        forever begin
            bit ack_now, v_pre;
            ev_t ev;
            @(posedge MCLK);
            cyc++;
            if (RESET) begin
                m_left = '0; m_right = '0;
                m_valid = 0; m_overrun = 0; m_ferr = 0;
                evq.delete();
            end else begin
                ack_now = ack;
                v_pre   = m_valid;
                m_ferr  = 0;
                if (m_valid && ack_now) m_valid = 0;
                while (evq.size() > 0 && evq[0].t <= cyc) begin
                    ev = evq.pop_front();
                    if (ev.is_pair) begin
                        if (!v_pre || ack_now) begin
                            m_left  = ev.l;
                            m_right = ev.r;
                            m_valid = 1;
                        end else begin
                            m_overrun = 1;
                        end
                    end else begin
                        m_ferr = 1;
                    end
                end
            end
        end
    end

    // Compare process.
    initial begin
        forever begin
            @(negedge MCLK);
            if (cyc > 0) begin
                chk("left",      bus.LEFT,                  m_left);
                chk("right",     bus.RIGHT,                 m_right);
                chk("valid",     24'(bus.SAMPLE_VALID),     24'(m_valid));
                chk("overrun",   24'(bus.OVERRUN),          24'(m_overrun));
                chk("frame_err", 24'(bus.FRAME_ERR),        24'(m_ferr));
                if (bus.SAMPLE_VALID === 1'b1) vcount++;
                if (bus.FRAME_ERR === 1'b1) fcount++;
            end
        end
    end

    task automatic tick();
        @(posedge MCLK);
        #1;
    endtask

    task automatic send_bit(input bit lr, input bit d, input bit ack_pulse);
        SCLK = 1'b0; LRCLK = lr; DOUT = d;
        tick();
        if (ack_clear_pending) begin
            ack = 1'b0;
            ack_clear_pending = 0;
        end
        tick();
        SCLK = 1'b1;
        rises++;
        if (phase == 2 && rises == DW + 1)
            evq.push_back('{cyc + LAT, 1'b1, left_saved, cur_word});
        tick();
        tick();
        if (ack_pulse) begin
            ack = 1'b1;
            ack_clear_pending = 1;
        end
    endtask

    task automatic slot_start(input bit ch);
        if (ch != cur_lr) begin
            case (phase)
                0: if (ch == 1'b0) phase = 1;
                1: if (rises >= DW + 1) begin
                       phase = 2;
                       left_saved = cur_word;
                   end else begin
                       evq.push_back('{cyc + LAT, 1'b0, 24'h0, 24'h0});
                       phase = 0;
                   end
                default: if (rises >= DW + 1) begin
                       phase = 1;
                   end else begin
                       evq.push_back('{cyc + LAT, 1'b0, 24'h0, 24'h0});
                       phase = 0;
                   end
            endcase
            rises = 0;
        end
        cur_lr = ch;
    endtask

    // Positions first..last of a 32-bit slot; position 0 carries the previous LSB.
    task automatic send_slot(input bit ch, input logic [23:0] word, input int first,
                             input int last, input int ack_pos);
        bit d;
        for (int p = first; p <= last; p++) begin
            if (p == 0) slot_start(ch);
            cur_word = word;
            if (p == 0)       d = last_lsb;
            else if (p <= DW) d = word[DW-p];
            else              d = 1'b0;
            send_bit(ch, d, p == ack_pos);
        end
        if (last >= DW) last_lsb = word[0];
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input int ack_pos);
        send_slot(1'b0, l, 0, 31, -1);
        send_slot(1'b1, r, 0, 31, ack_pos);
    endtask

    initial begin
        repeat (4) tick();
        RESET = 1'b0;
        chk("reset_valid", 24'(bus.SAMPLE_VALID), 24'h0);
        chk("reset_left",  bus.LEFT, 24'h0);

        // start-up mid right slot, then one full frame
        vcount = 0;
        send_slot(1'b1, 24'h000000, 20, 31, -1);
        send_frame(24'h111111, 24'h222222, -1);
        chk("t3_pairs", 24'(vcount), 24'd1);
        chk("t3_left",  bus.LEFT,  24'h111111);
        chk("t3_right", bus.RIGHT, 24'h222222);

        // basic capture with ack tied high
        vcount = 0;
        send_frame(24'hABCDEF, 24'h123456, -1);
        chk("t1_pulse",   24'(vcount), 24'd1);
        chk("t1_left",    bus.LEFT,  24'hABCDEF);
        chk("t1_right",   bus.RIGHT, 24'h123456);
        chk("t1_model_l", m_left,    24'hABCDEF);

        // ack coincident with a completing pair
        ack = 1'b0;
        send_frame(24'h5A5A5A, 24'hA5A5A5, -1);
        chk("t6_pend", 24'(bus.SAMPLE_VALID), 24'h1);
        send_frame(24'h13579B, 24'h2468AC, DW);
        chk("t6_valid",   24'(bus.SAMPLE_VALID), 24'h1);
        chk("t6_left",    bus.LEFT,  24'h13579B);
        chk("t6_right",   bus.RIGHT, 24'h2468AC);
        chk("t6_overrun", 24'(bus.OVERRUN), 24'h0);

        // short left slot, then a good frame
        ack = 1'b1;
        tick();
        vcount = 0;
        fcount = 0;
        send_slot(1'b0, 24'hFFFFFF, 0, 19, -1);
        send_slot(1'b1, 24'h777777, 0, 31, -1);
        send_frame(24'hC0FFEE, 24'hBADBAD, -1);
        chk("t4_ferr",  24'(fcount), 24'd1);
        chk("t4_pairs", 24'(vcount), 24'd1);
        chk("t4_left",  bus.LEFT,  24'hC0FFEE);
        chk("t4_right", bus.RIGHT, 24'hBADBAD);

        // overrun with ack held low
        ack = 1'b0;
        send_frame(24'h000001, 24'h800000, -1);
        send_frame(24'h7FFFFF, 24'hFFFFFF, -1);
        send_frame(24'h0A0A0A, 24'h050505, -1);
        chk("t2_left",    bus.LEFT,  24'h000001);
        chk("t2_right",   bus.RIGHT, 24'h800000);
        chk("t2_overrun", 24'(bus.OVERRUN), 24'h1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        chk("t2_acked", 24'(bus.SAMPLE_VALID), 24'h0);
        send_frame(24'h246802, 24'h97531F, -1);
        chk("t2_new_l", bus.LEFT,  24'h246802);
        chk("t2_new_r", bus.RIGHT, 24'h97531F);

        // reset mid left word
        ack = 1'b1;
        send_slot(1'b0, 24'h654321, 0, 12, -1);
        RESET = 1'b1;
        repeat (3) tick();
        RESET = 1'b0;
        phase = 0;
        rises = 0;
        chk("t5_left",    bus.LEFT,  24'h0);
        chk("t5_right",   bus.RIGHT, 24'h0);
        chk("t5_overrun", 24'(bus.OVERRUN), 24'h0);
        vcount = 0;
        send_slot(1'b0, 24'h654321, 13, 31, -1);
        send_slot(1'b1, 24'h0F0F0F, 0, 31, -1);
        chk("t5_nopair", 24'(vcount), 24'd0);
        send_frame(24'hFEDCBA, 24'h012345, -1);
        chk("t5_pairs", 24'(vcount), 24'd1);
        chk("t5_new_l", bus.LEFT,  24'hFEDCBA);
        chk("t5_new_r", bus.RIGHT, 24'h012345);

        repeat (8) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
